proj_base_streamer: RTL and testbench
=====================================

# proj_base_streamer

Source side of the base stream consumed by the minhash top. Accepts packed sequence words (WORD_BASES bases per word) over a valid/ready handshake and serialises them one base per cycle onto the top-level `in_data` bus. It honours the top's `out_wait` back-pressure and marks the last base of each read.

## Interface

Parameters:
- BASE_LEN, 2, bits per base (matches proj_pkg encoding).
- WORD_BASES, 16, bases packed per input word.
- CNT_W, $clog2(WORD_BASES+1), width of the base-count field.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_word  input  WORD_BASES*BASE_LEN  packed bases; base k is at bits [k*BASE_LEN +: BASE_LEN]; base 0 is sent first.
- in_valid  input  1  in_word is valid.
- in_last  input  1  this word ends the current read.
- in_nbases  input  CNT_W  number of valid bases in a last word; ignored when in_last=0.
- in_ready  output  1  word accepted on an edge where in_valid && in_ready.
- in_wait  input  1  downstream stall; drive this from the top's out_wait.
- out_base  output  BASE_LEN  current base; drive this to the top's in_data.
- out_valid  output  1  out_base is meaningful.
- out_last  output  1  out_base is the final base of a read.
- err_nbases  output  1  sticky flag: a last word arrived with an illegal in_nbases.

## Operation

- State machine has two states:
  - EMPTY: no word is held.
  - SHIFT: a word is held, with base index `idx` and limit `lim`.
- Accept: when in_valid && in_ready, the block latches the word, sets idx=0, and sets lim as follows:
  - lim = WORD_BASES if in_last=0.
  - lim = in_nbases if in_last=1.
- Illegal count: if in_last=1 and in_nbases is 0 or greater than WORD_BASES, lim = WORD_BASES and err_nbases is set. err_nbases clears only on reset.
- A base is consumed on an edge where out_valid && !in_wait; idx then increments.
- out_base = word[idx]. out_valid = (state==SHIFT).
- out_last = held in_last && idx==lim-1.
- While in_wait=1: out_base, out_valid, out_last and idx hold; no word is accepted unless the block is EMPTY.
- in_ready (combinational) = EMPTY, or (SHIFT && idx==lim-1 && !in_wait). This gives zero-bubble back-to-back words.
- After the last base is consumed:
  - If a new word is accepted on the same edge, the state stays SHIFT and idx=0.
  - Otherwise the state goes to EMPTY.
- No partial-read state crosses words; the read boundary is carried only by in_last.

## Timing

- Reset values: out_valid 0, out_base 0, out_last 0, err_nbases 0, state EMPTY, so in_ready=1 after reset.
- Latency: a word accepted at edge N presents base 0 in the cycle after edge N.
- A word of L bases with no stalls occupies exactly L output cycles. Stall cycles add 1:1.
- Simultaneous consume-last and accept: no gap between the two words' bases.
- Reset asserted mid-word: the held word is dropped and outputs take reset values immediately (asynchronously). The next word after release starts at base 0.
- in_wait asserted while EMPTY has no effect; in_ready stays 1.

## Configuration

- PROJ_STREAMER_SKID_EN defined:
  - A 2-entry word FIFO sits in front of the shifter.
  - in_ready = FIFO not full (registered), independent of in_wait.
  - Accept-to-first-base latency stays 1 cycle when the shifter is idle.
  - When the shifter finishes a word, it loads from the FIFO on the same edge, with no bubble.
- PROJ_STREAMER_SKID_EN undefined: single holding register; in_ready follows the combinational rule above.
- Output sequence, out_last and err_nbases are identical in both builds for the same accepted words and in_wait pattern.

## Test plan

- One word 0x000000E4 (bases 0,1,2,3 then zeros), in_last=0, in_wait=0 -> out_base 0,1,2,3,0×12 on 16 consecutive cycles; out_last never set.
- Two back-to-back words, second with in_last=1, in_nbases=5 -> 21 contiguous out_valid cycles; out_last only on cycle 21; in_ready high on the 16th base cycle.
- in_wait held high for 3 cycles at idx=7 -> base 7 repeats for 4 cycles, then idx=8; total 19 cycles for 16 bases.
- in_last=1, in_nbases=0 -> 16 bases emitted; err_nbases=1 from the cycle after accept and stays set until rst_n=0.
- rst_n pulsed low at idx=9 -> out_valid=0 and out_base=0 immediately; a new word 0xFFFFFFFF then gives base 3 starting 1 cycle after accept.
- (SKID build) in_valid held high with in_wait=1 -> exactly 2 further words accepted after the held word, then in_ready=0.

Source files
------------

// File: rtl/proj_base_streamer.sv
// Serialises packed base words onto the minhash in_data bus, one base per cycle, with back-pressure.
// Optional PROJ_STREAMER_SKID_EN adds a 2-entry word FIFO in front of the shifter.
//
// state | meaning
// EMPTY | no word held; ready for a new word
// SHIFT | word held; presenting base idx, final base at lim-1
module proj_base_streamer #(
    parameter int BASE_LEN   = 2,
    parameter int WORD_BASES = 16,
    parameter int CNT_W      = $clog2(WORD_BASES + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WORD_BASES*BASE_LEN-1:0] in_word,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [CNT_W-1:0]             in_nbases,
    output logic                         in_ready,
    input  logic                         in_wait,
    output logic [BASE_LEN-1:0]          out_base,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         err_nbases
);

    localparam int IDX_W = (WORD_BASES > 1) ? $clog2(WORD_BASES) : 1;

    typedef enum logic {EMPTY, SHIFT} state_t;
    typedef logic [WORD_BASES-1:0][BASE_LEN-1:0] word_t;

    state_t           state;
    word_t            word_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] lim_q;
    logic             last_q;

    logic             fire;
    logic             at_end;
    logic             shift_take;
    logic             accept;
    logic             nb_bad;
    logic [CNT_W-1:0] in_lim;

    logic             load;
    word_t            ld_word;
    logic             ld_last;
    logic [CNT_W-1:0] ld_lim;

    // An illegal count on a last word falls back to a full word.
    assign nb_bad = in_last && ((in_nbases == '0) || (in_nbases > CNT_W'(WORD_BASES)));
    assign in_lim = (in_last && !nb_bad) ? in_nbases : CNT_W'(WORD_BASES);

    assign fire       = (state == SHIFT) && !in_wait;
    assign at_end     = (idx_q == (lim_q - 1'b1));
    assign shift_take = (state == EMPTY) || (fire && at_end);
    assign accept     = in_valid && in_ready;

`ifdef PROJ_STREAMER_SKID_EN
    localparam int ENT_W = WORD_BASES*BASE_LEN + 1 + CNT_W;

    logic [ENT_W-1:0] fifo_q [2];
    logic [1:0]       cnt_q;
    logic [ENT_W-1:0] in_ent;
    logic             direct;
    logic             push;
    logic             pop;

    assign in_ent   = {in_word, in_last, in_lim};
    assign in_ready = (cnt_q != 2'd2);

    // With an empty FIFO and an idle shifter the word bypasses the FIFO to keep 1-cycle latency.
    assign direct = shift_take && (cnt_q == 2'd0);
    assign pop    = shift_take && (cnt_q != 2'd0);
    assign push   = accept && !direct;
    assign load   = pop || (direct && accept);
    assign {ld_word, ld_last, ld_lim} = pop ? fifo_q[0] : in_ent;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 2'd0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else if (push && pop) begin
            fifo_q[0] <= in_ent;
        end else if (push) begin
            if (cnt_q == 2'd0) fifo_q[0] <= in_ent;
            else               fifo_q[1] <= in_ent;
            cnt_q <= cnt_q + 2'd1;
        end else if (pop) begin
            fifo_q[0] <= fifo_q[1];
            cnt_q     <= cnt_q - 2'd1;
        end
    end
`else
    assign in_ready = shift_take;
    assign load     = accept;
    assign ld_word  = in_word;
    assign ld_last  = in_last;
    assign ld_lim   = in_lim;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            word_q     <= '0;
            idx_q      <= '0;
            lim_q      <= '0;
            last_q     <= 1'b0;
            err_nbases <= 1'b0;
        end else begin
            if (accept && nb_bad) err_nbases <= 1'b1;
            if (load) begin
                state  <= SHIFT;
                word_q <= ld_word;
                idx_q  <= '0;
                lim_q  <= ld_lim;
                last_q <= ld_last;
            end else if (fire) begin
                if (at_end) state <= EMPTY;
                else        idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign out_valid = (state == SHIFT);
    assign out_base  = out_valid ? word_q[idx_q[IDX_W-1:0]] : '0;
    assign out_last  = out_valid && last_q && at_end;

endmodule

// File: tb/tb_proj_base_streamer.sv
// Directed bench for proj_base_streamer; inputs change on negedge/after posedge, outputs checked at negedge.
module tb_proj_base_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_last;
    logic [4:0]  in_nbases;
    logic        in_ready;
    logic        in_wait;
    logic [1:0]  out_base;
    logic        out_valid;
    logic        out_last;
    logic        err_nbases;

    int total = 0;
    int bad   = 0;

    proj_base_streamer #(.BASE_LEN(2), .WORD_BASES(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
        .in_last(in_last), .in_nbases(in_nbases), .in_ready(in_ready),
        .in_wait(in_wait), .out_base(out_base), .out_valid(out_valid),
        .out_last(out_last), .err_nbases(err_nbases)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] base_of(input logic [31:0] w, input int k);
        logic [31:0] t;
        t = w >> (2 * k);
        return t[1:0];
    endfunction

    task automatic start_word(input logic [31:0] w, input logic last, input logic [4:0] nb);
        @(negedge clk);
        in_word = w; in_last = last; in_nbases = nb; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_word = '0; in_valid = 1'b0; in_last = 1'b0; in_nbases = '0; in_wait = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, out_base, out_last, err_nbases, in_ready} !== 6'b0_00_0_0_1) begin
            bad++; $display("FAIL reset_values got=%b exp=%b", {out_valid, out_base, out_last, err_nbases, in_ready}, 6'b000001);
        end
        rst_n = 1'b1;
        in_wait = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL wait_while_empty got=%b exp=01", {out_valid, in_ready});
        end
        in_wait = 1'b0;
    endtask

    task automatic test_single_word;
        logic [1:0] e;
        start_word(32'h0000_00E4, 1'b0, 5'd0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            e = (c < 4) ? 2'(c) : 2'd0;
            total++;
            if ({out_valid, out_base, out_last} !== {1'b1, e, 1'b0}) begin
                bad++; $display("FAIL single_word cyc=%0d got=%b exp=%b", c, {out_valid, out_base, out_last}, {1'b1, e, 1'b0});
            end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_word_end out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [1:0] bb [5];
        logic [1:0] e;
        logic go;
        bb = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        start_word(32'hFFAA_5500, 1'b0, 5'd0);
        go = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            e = (c <= 16) ? 2'((c - 1) / 4) : bb[c - 17];
            total++;
            if ({out_valid, out_base, out_last} !== {1'b1, e, c == 21}) begin
                bad++; $display("FAIL back_to_back cyc=%0d got=%b exp=%b", c, {out_valid, out_base, out_last}, {1'b1, e, c == 21});
            end
            if (c == 16) begin
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_at_16 in_ready=%b exp=1", in_ready); end
            end
`ifndef PROJ_STREAMER_SKID_EN
            if (c == 2) begin
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_mid in_ready=%b exp=0", in_ready); end
            end
`endif
            if (go) begin in_valid = 1'b0; in_last = 1'b0; end
            if (c == 1) begin in_word = 32'h0000_03E4; in_last = 1'b1; in_nbases = 5'd5; in_valid = 1'b1; end
            go = in_valid && in_ready;
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_stall;
        logic [31:0] w;
        int idx;
        w = 32'hC6A5_93E4;
        start_word(w, 1'b0, 5'd0);
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            idx = (c <= 8) ? c - 1 : ((c <= 11) ? 7 : c - 4);
            total++;
            if ({out_valid, out_base, out_last} !== {1'b1, base_of(w, idx), 1'b0}) begin
                bad++; $display("FAIL stall cyc=%0d got=%b exp=%b", c, {out_valid, out_base, out_last}, {1'b1, base_of(w, idx), 1'b0});
            end
            if (c == 8)  in_wait = 1'b1;
            if (c == 11) in_wait = 1'b0;
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_end out_valid=%b exp=0", out_valid); end
    endtask

    // Last words whose counts sit on the legal edges, or beyond them (nb of 0 or 17 -> full word + error).
    task automatic test_nbases(input logic [4:0] nb, input logic exp_err);
        int n;
        logic [1:0] e;
        n = (nb == 5'd0 || nb > 5'd16) ? 16 : int'(nb);
        start_word(32'h1B1B_1B1B, 1'b1, nb);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e = 2'(3 - (c % 4));
            total++;
            if ({out_valid, out_base, out_last, err_nbases} !== {1'b1, e, c == n - 1, exp_err}) begin
                bad++; $display("FAIL nbases_%0d cyc=%0d got=%b exp=%b", nb, c, {out_valid, out_base, out_last, err_nbases}, {1'b1, e, c == n - 1, exp_err});
            end
        end
        @(negedge clk);
        total++;
        if ({out_valid, err_nbases} !== {1'b0, exp_err}) begin
            bad++; $display("FAIL nbases_%0d_end got=%b exp=%b", nb, {out_valid, err_nbases}, {1'b0, exp_err});
        end
    endtask

    task automatic test_reset_mid;
        start_word(32'h1B1B_1B1B, 1'b0, 5'd0);
        repeat (10) @(negedge clk);
        total++;
        if ({out_valid, out_base} !== 3'b1_10) begin bad++; $display("FAIL rst_mid_pre got=%b exp=110", {out_valid, out_base}); end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_base, out_last, err_nbases, in_ready} !== 6'b0_00_0_0_1) begin
            bad++; $display("FAIL rst_mid_async got=%b exp=000001", {out_valid, out_base, out_last, err_nbases, in_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_word(32'hFFFF_FFFF, 1'b0, 5'd0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            total++;
            if ({out_valid, out_base, out_last} !== 4'b1_11_0) begin
                bad++; $display("FAIL rst_mid_after cyc=%0d got=%b exp=1110", c, {out_valid, out_base, out_last});
            end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_end out_valid=%b exp=0", out_valid); end
    endtask

`ifdef PROJ_STREAMER_SKID_EN
    task automatic test_skid;
        logic [31:0] ws [4];
        logic go;
        int k, acc;
        ws = '{32'h0000_00E4, 32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_wait = 1'b1; in_last = 1'b0;
        k = 0; in_word = ws[0]; in_valid = 1'b1;
        go = in_valid && in_ready; acc = go ? 1 : 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (go && k < 3) begin k++; in_word = ws[k]; end
            go = in_valid && in_ready;
            if (go) acc++;
        end
        total++;
        if (acc != 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL skid_fill accepted=%0d ready=%b valid=%b exp 3/0/1", acc, in_ready, out_valid);
        end
        in_valid = 1'b0; in_wait = 1'b0;
        for (int c = 0; c < 48; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if ({out_valid, out_base} !== {1'b1, base_of(ws[c / 16], c % 16)}) begin
                bad++; $display("FAIL skid_drain cyc=%0d got=%b exp=%b", c, {out_valid, out_base}, {1'b1, base_of(ws[c / 16], c % 16)});
            end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL skid_end out_valid=%b exp=0", out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_nbases(5'd1, 1'b0);
        test_nbases(5'd16, 1'b0);
        test_nbases(5'd0, 1'b1);
        test_reset_mid();
        test_nbases(5'd17, 1'b1);
`ifdef PROJ_STREAMER_SKID_EN
        test_skid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
